ping_scheduler: RTL and testbench
=================================

# ping_scheduler

Sequences one ultrasonic ranging cycle: drives the transmitter burst, blanks the receiver while the transducer rings, times the echo, and reports a time-of-flight count in clock cycles. It sits between the user/host trigger logic and the transmitter/receiver front end. It owns the cycle counter that the ranging datapath converts to distance.

## Interface
- BURST_CYCLES, 25000: cycles `tx_en_out` is high per ping.
- BLANK_CYCLES, 100000: cycles after the burst during which `echo_in` is ignored.
- TIMEOUT_CYCLES, 2500000: maximum time-of-flight count; must exceed BURST_CYCLES+BLANK_CYCLES.
- HOLDOFF_CYCLES, 1000000: dead time after a result before a new start is accepted.
- CW, $clog2(TIMEOUT_CYCLES): width of the time-of-flight count (derived).
- clk_in  in  1  system clock; single clock domain.
- rst_n_in  in  1  asynchronous, active-low reset.
- start_in  in  1  one-cycle request to begin a ping; honoured only in IDLE.
- cancel_in  in  1  abort the current ping; return to IDLE.
- echo_in  in  1  receiver comparator output, already synchronized to clk_in.
- busy_out  out  1  high whenever state ≠ IDLE.
- tx_en_out  out  1  transmitter enable.
- result_valid_out  out  1  one-cycle pulse when a result is ready.
- result_timeout_out  out  1  qualifies result_valid_out: no echo before timeout.
- tof_out  out  CW  time-of-flight count; holds its value between results.

## Operation
- States: IDLE, BURST, BLANK, LISTEN, HOLDOFF.
- tof counter (CW bits) is 0 in the first BURST cycle and increments by 1 every cycle through BURST, BLANK and LISTEN. It never wraps.
- IDLE: if start_in=1 and cancel_in=0, go to BURST and clear the counter. If both are high, cancel wins and the block stays in IDLE.
- BURST: tx_en_out=1. When counter = BURST_CYCLES−1, go to BLANK.
- BLANK: echo_in is ignored. When counter = BURST_CYCLES+BLANK_CYCLES−1, go to LISTEN.
- LISTEN: an echo is a rising edge, i.e. echo_in=1 this cycle and echo_prev=0.
  - echo_prev is registered every cycle in every state.
  - An echo_in already high on entry does not count; it must fall and rise again.
  - Echo at counter value N: register tof_out=N, result_timeout_out=0, pulse result_valid_out, go to HOLDOFF.
  - No echo and counter = TIMEOUT_CYCLES−1: register tof_out=TIMEOUT_CYCLES−1, result_timeout_out=1, pulse result_valid_out, go to HOLDOFF.
  - An echo edge on the timeout cycle takes precedence: it is reported as an echo with result_timeout_out=0.
- HOLDOFF: a separate counter runs for exactly HOLDOFF_CYCLES cycles, then the block returns to IDLE.
- start_in in any non-IDLE state is ignored, with no queueing.
- cancel_in in BURST, BLANK, LISTEN or HOLDOFF: go to IDLE next cycle. No result is produced, and tof_out and result_timeout_out keep their previous values.
- Reset: state=IDLE, counters=0, echo_prev=0, and all outputs 0, including tof_out and result_timeout_out.

## Timing
- All outputs are registered.
- tx_en_out rises one cycle after the start_in cycle and stays high for exactly BURST_CYCLES cycles.
- result_valid_out rises in the cycle after the detecting cycle and is high for exactly 1 cycle. tof_out and result_timeout_out are valid in that same cycle and remain stable afterwards.
- busy_out rises with tx_en_out. It stays high through HOLDOFF and falls HOLDOFF_CYCLES cycles after the result_valid_out cycle.
- Earliest next start is accepted in the cycle busy_out is low.
- Cancel: tx_en_out and busy_out are 0 in the cycle after cancel_in.
- Reset assertion forces all outputs to 0 immediately, without waiting for a clock edge. The first start is accepted on the first edge after deassertion.

## Test plan
All scenarios use BURST=4, BLANK=6, TIMEOUT=40, HOLDOFF=5.
- Start pulse, echo_in rises at counter 20 → tx_en_out high for 4 cycles; result_valid_out pulses with tof_out=20 and result_timeout_out=0; busy_out falls 5 cycles later.
- Start pulse, echo_in held low → result_valid_out pulses with tof_out=39 and result_timeout_out=1.
- echo_in pulses only at counter 7 (BLANK) → echo ignored; timeout result with tof_out=39.
- echo_in high from counter 8 to 15, then low, then rising at 25 → tof_out=25. Separately, an edge exactly at counter 39 → tof_out=39 with result_timeout_out=0.
- cancel_in at counter 2 → tx_en_out=0 and busy_out=0 next cycle; no result_valid_out. A following start runs a full ping normally.
- start_in during HOLDOFF → ignored, no second burst. rst_n_in low during LISTEN → all outputs 0 immediately; start after release gives a normal ping.

Source files
------------

// File: rtl/ping_scheduler.sv
// ping_scheduler: sequences one ultrasonic ranging cycle (burst, blanking, echo timing, holdoff)
//   clk_in             system clock
//   rst_n_in           asynchronous active-low reset
//   start_in           one-cycle ping request, honoured only when idle
//   cancel_in          abort the current ping and return to idle
//   echo_in            synchronized receiver comparator output
//   busy_out           high whenever a ping or its holdoff is in progress
//   tx_en_out          transmitter enable, high for BURST_CYCLES per ping
//   result_valid_out   one-cycle pulse when tof_out/result_timeout_out are updated
//   result_timeout_out no echo was seen before TIMEOUT_CYCLES-1
//   tof_out            time-of-flight in clock cycles, held between results
module ping_scheduler #(
    parameter int BURST_CYCLES   = 25000,
    parameter int BLANK_CYCLES   = 100000,
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int HOLDOFF_CYCLES = 1000000,
    parameter int CW             = $clog2(TIMEOUT_CYCLES)
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          start_in,
    input  logic          cancel_in,
    input  logic          echo_in,
    output logic          busy_out,
    output logic          tx_en_out,
    output logic          result_valid_out,
    output logic          result_timeout_out,
    output logic [CW-1:0] tof_out
);
    // +1 keeps the width non-zero when HOLDOFF_CYCLES is 1
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_BURST   = 3'd1;
    localparam logic [2:0] S_BLANK   = 3'd2;
    localparam logic [2:0] S_LISTEN  = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;

    localparam logic [CW-1:0] BURST_END   = CW'(BURST_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_END   = CW'(BURST_CYCLES + BLANK_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_END = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_END    = HW'(HOLDOFF_CYCLES - 1);

    logic [2:0]    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [HW-1:0] hcnt, hcnt_nx;
    logic          echo_prev;
    logic          echo_edge;
    logic          fire;
    logic          timeout_hit;

    // echo_prev tracks every cycle, so a level already high on entry to LISTEN never looks like an edge
    assign echo_edge = echo_in & ~echo_prev;

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        hcnt_nx     = hcnt;
        fire        = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_in && !cancel_in) begin
                    state_nx = S_BURST;
                    cnt_nx   = '0;
                end
            end
            S_BURST: begin
                if (cancel_in) begin
                    state_nx = S_IDLE;
                end else begin
                    cnt_nx   = cnt + 1'b1;
                    state_nx = (cnt == BURST_END) ? S_BLANK : S_BURST;
                end
            end
            S_BLANK: begin
                if (cancel_in) begin
                    state_nx = S_IDLE;
                end else begin
                    cnt_nx   = cnt + 1'b1;
                    state_nx = (cnt == BLANK_END) ? S_LISTEN : S_BLANK;
                end
            end
            S_LISTEN: begin
                // an edge on the final cycle still counts as a real echo
                if (cancel_in) begin
                    state_nx = S_IDLE;
                end else if (echo_edge || cnt == TIMEOUT_END) begin
                    fire        = 1'b1;
                    timeout_hit = !echo_edge;
                    state_nx    = S_HOLDOFF;
                    hcnt_nx     = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_HOLDOFF: begin
                if (cancel_in || hcnt == HOLD_END) begin
                    state_nx = S_IDLE;
                end else begin
                    hcnt_nx = hcnt + 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state              <= S_IDLE;
            cnt                <= '0;
            hcnt               <= '0;
            echo_prev          <= 1'b0;
            busy_out           <= 1'b0;
            tx_en_out          <= 1'b0;
            result_valid_out   <= 1'b0;
            result_timeout_out <= 1'b0;
            tof_out            <= '0;
        end else begin
            state            <= state_nx;
            cnt              <= cnt_nx;
            hcnt             <= hcnt_nx;
            echo_prev        <= echo_in;
            busy_out         <= state_nx != S_IDLE;
            tx_en_out        <= state_nx == S_BURST;
            result_valid_out <= fire;
            if (fire) begin
                tof_out            <= cnt;
                result_timeout_out <= timeout_hit;
            end
        end
    end
endmodule

// File: tb/tb_ping_scheduler.sv
// tb_ping_scheduler: randomized and directed checks of ping_scheduler against a timeline model
module tb_ping_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cancel = 1'b0;
    logic       echo = 1'b0;
    logic       busy, tx_en, rv, rto;
    logic [5:0] tof;
    int         checks = 0;
    int         errors = 0;
    logic [5:0] exp_tof = '0;
    logic       exp_to = 1'b0;

    ping_scheduler #(
        .BURST_CYCLES(4), .BLANK_CYCLES(6), .TIMEOUT_CYCLES(40), .HOLDOFF_CYCLES(5)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .cancel_in(cancel), .echo_in(echo),
        .busy_out(busy), .tx_en_out(tx_en), .result_valid_out(rv),
        .result_timeout_out(rto), .tof_out(tof)
    );

    always #5 clk = ~clk;

    // p[k+1] is the echo level while the ping counter equals k; p[0] is the level in the start cycle.
    // The ping starts with start driven at step j=0; at step j>=1 the counter reads j-1.
    task automatic run_ping(input logic [40:0] p, input bit noisy, input int cancel_j, input string name);
        int  kd, jr, last;
        bit  to;
        logic e_tx, e_busy, e_rv;
        kd = 39;
        to = 1'b1;
        for (int k = 39; k >= 10; k--)
            if (p[k+1] && !p[k]) begin
                kd = k;
                to = 1'b0;
            end
        jr   = kd + 2;
        last = (cancel_j >= 0) ? cancel_j : kd + 6;
        for (int j = 0; j <= last; j++) begin
            @(negedge clk);
            if (j == jr) begin
                exp_tof = 6'(kd);
                exp_to  = to;
            end
            e_tx   = (j >= 1 && j <= 4);
            e_busy = (j >= 1);
            e_rv   = (j == jr);
            checks += 5;
            if (tx_en !== e_tx) begin errors++; $display("FAIL %s tx_en j=%0d got %b want %b", name, j, tx_en, e_tx); end
            if (busy !== e_busy) begin errors++; $display("FAIL %s busy j=%0d got %b want %b", name, j, busy, e_busy); end
            if (rv !== e_rv) begin errors++; $display("FAIL %s result_valid j=%0d got %b want %b", name, j, rv, e_rv); end
            if (tof !== exp_tof) begin errors++; $display("FAIL %s tof j=%0d got %0d want %0d", name, j, tof, exp_tof); end
            if (rto !== exp_to) begin errors++; $display("FAIL %s timeout j=%0d got %b want %b", name, j, rto, exp_to); end
            cancel = (j == cancel_j);
            start  = (j == 0) || (noisy && j != cancel_j && (j == kd + 3 || $urandom_range(0, 3) == 0));
            echo   = (j <= 40 && j <= kd + 1) ? p[j] : (noisy ? 1'($urandom_range(0, 1)) : 1'b0);
        end
    endtask

    task automatic idle(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks += 5;
            if (tx_en !== 1'b0) begin errors++; $display("FAIL %s idle tx_en i=%0d got %b want 0", name, i, tx_en); end
            if (busy !== 1'b0) begin errors++; $display("FAIL %s idle busy i=%0d got %b want 0", name, i, busy); end
            if (rv !== 1'b0) begin errors++; $display("FAIL %s idle result_valid i=%0d got %b want 0", name, i, rv); end
            if (tof !== exp_tof) begin errors++; $display("FAIL %s idle tof i=%0d got %0d want %0d", name, i, tof, exp_tof); end
            if (rto !== exp_to) begin errors++; $display("FAIL %s idle timeout i=%0d got %b want %b", name, i, rto, exp_to); end
            start  = 1'b0;
            cancel = 1'b0;
            echo   = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic check_zero(input string name);
        checks += 5;
        if (tx_en !== 1'b0) begin errors++; $display("FAIL %s tx_en got %b want 0", name, tx_en); end
        if (busy !== 1'b0) begin errors++; $display("FAIL %s busy got %b want 0", name, busy); end
        if (rv !== 1'b0) begin errors++; $display("FAIL %s result_valid got %b want 0", name, rv); end
        if (tof !== 6'd0) begin errors++; $display("FAIL %s tof got %0d want 0", name, tof); end
        if (rto !== 1'b0) begin errors++; $display("FAIL %s timeout got %b want 0", name, rto); end
    endtask

    task automatic test_reset;
        start = 1'b1;
        #3 check_zero("reset_async");
        repeat (2) @(posedge clk);
        #1 check_zero("reset_held");
        start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [40:0] p;
        p = '0;
        for (int k = 20; k <= 39; k++) p[k+1] = 1'b1;
        run_ping(p, 1'b0, -1, "echo20");
        run_ping('0, 1'b0, -1, "timeout");
        p = '0;
        p[8] = 1'b1;
        run_ping(p, 1'b0, -1, "blank_pulse");
        p = '0;
        for (int k = 8; k <= 15; k++) p[k+1] = 1'b1;
        for (int k = 25; k <= 30; k++) p[k+1] = 1'b1;
        run_ping(p, 1'b0, -1, "reentry25");
        p = '0;
        p[40] = 1'b1;
        run_ping(p, 1'b0, -1, "edge39");
        p = '0;
        for (int k = 5; k <= 20; k++) p[k+1] = 1'b1;
        run_ping(p, 1'b0, -1, "high_on_entry");
    endtask

    task automatic test_cancel;
        logic [40:0] p;
        run_ping('0, 1'b0, 3, "cancel_burst");
        idle(3, "cancel_burst");
        p = '0;
        for (int k = 18; k <= 39; k++) p[k+1] = 1'b1;
        run_ping(p, 1'b0, -1, "after_cancel");
        run_ping(p, 1'b0, 22, "cancel_holdoff");
        idle(2, "cancel_holdoff");
        @(negedge clk);
        start  = 1'b1;
        cancel = 1'b1;
        idle(3, "start_cancel_idle");
    endtask

    task automatic test_holdoff_start;
        logic [40:0] p;
        p = '0;
        for (int k = 12; k <= 39; k++) p[k+1] = 1'b1;
        run_ping(p, 1'b1, -1, "holdoff_start");
        idle(2, "holdoff_start");
    endtask

    task automatic test_reset_listen;
        logic [40:0] p;
        for (int j = 0; j <= 16; j++) begin
            @(negedge clk);
            start = (j == 0);
            echo  = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_zero("reset_listen");
        exp_tof = '0;
        exp_to  = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        p = '0;
        for (int k = 30; k <= 39; k++) p[k+1] = 1'b1;
        run_ping(p, 1'b0, -1, "after_reset");
    endtask

    task automatic test_back_to_back;
        logic [40:0] p;
        int kd, cj;
        for (int n = 0; n < 40; n++) begin
            p = '0;
            if ($urandom_range(0, 4) != 0)
                for (int k = 0; k <= 40; k++) p[k] = ($urandom_range(0, 5) == 0);
            kd = 39;
            for (int k = 39; k >= 10; k--) if (p[k+1] && !p[k]) kd = k;
            cj = -1;
            if ($urandom_range(0, 3) == 0) begin
                cj = $urandom_range(1, kd + 6);
                if (cj == kd + 1) cj = kd + 2;
            end
            run_ping(p, 1'b1, cj, "random");
            if (cj >= 0) idle($urandom_range(1, 3), "random_cancel");
            else if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2), "random_gap");
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_cancel;
        test_holdoff_start;
        test_reset_listen;
        test_back_to_back;
        idle(2, "final");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
